// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic intersection controller.
//   - State encodings (also visible on the o_state debug port).
//   - State enum built on those encodings.
//   - Direction type, plus the direction assumed to have been served last
//     after reset (EW, so the first green is NS).
package traffic_pkg;

   localparam logic [2:0] ENC_IDLE      = 3'd0;
   localparam logic [2:0] ENC_NS_GREEN  = 3'd1;
   localparam logic [2:0] ENC_NS_YELLOW = 3'd2;
   localparam logic [2:0] ENC_ALL_RED   = 3'd3;
   localparam logic [2:0] ENC_PED_WALK  = 3'd4;
   localparam logic [2:0] ENC_EW_GREEN  = 3'd5;
   localparam logic [2:0] ENC_EW_YELLOW = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE      = ENC_IDLE,
      ST_NS_GREEN  = ENC_NS_GREEN,
      ST_NS_YELLOW = ENC_NS_YELLOW,
      ST_ALL_RED   = ENC_ALL_RED,
      ST_PED_WALK  = ENC_PED_WALK,
      ST_EW_GREEN  = ENC_EW_GREEN,
      ST_EW_YELLOW = ENC_EW_YELLOW
   } state_t;

   typedef enum logic {
      DIR_NS = 1'b0,
      DIR_EW = 1'b1
   } dir_t;

   localparam dir_t RESET_LAST_DIR = DIR_EW;

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter.
// A load pulse sets the count to load_value. Otherwise the count
// decrements once per cycle and saturates at zero.
//   clk        : clock
//   rst_n      : asynchronous active-low reset (count -> 0)
//   load       : load load_value this cycle
//   load_value : value to load (duration - 1)
//   count      : remaining cycles in the current phase
//   zero       : count == 0
module phase_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_value,
   output logic [3:0] count,
   output logic       zero
);

   logic [3:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= 4'd0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (count_reg != 4'd0) begin
         count_reg <= count_reg - 4'd1;
      end
   end

   assign count = count_reg;
   assign zero  = (count_reg == 4'd0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-way intersection controller with a pedestrian walk phase.
//
// Ports:
//   in_clk, in_rst_n          : clock, asynchronous active-low reset
//   in_en                     : run enable; low requests an orderly stop to IDLE
//   in_req_ns, in_req_ew      : vehicle sensors (level); only looked at in green
//   in_ped_req                : pedestrian button (a one-cycle pulse is latched)
//   o_ns_green/yellow/red     : north-south lamps
//   o_ew_green/yellow/red     : east-west lamps
//   o_walk                    : pedestrian walk lamp
//   o_count                   : remaining cycles in the current timed phase
//   o_state                   : current state encoding (debug)
//
// Lamps and o_walk are registered from the next state, so they change on
// the same edge as o_state and o_count.
module traffic_intersection_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned GREEN_MIN = 5,
   parameter int unsigned YELLOW_T  = 2,
   parameter int unsigned ALLRED_T  = 1,
   parameter int unsigned WALK_T    = 4
) (
   input  logic       in_clk,
   input  logic       in_rst_n,
   input  logic       in_en,
   input  logic       in_req_ns,
   input  logic       in_req_ew,
   input  logic       in_ped_req,
   output logic       o_ns_green,
   output logic       o_ns_yellow,
   output logic       o_ns_red,
   output logic       o_ew_green,
   output logic       o_ew_yellow,
   output logic       o_ew_red,
   output logic       o_walk,
   output logic [3:0] o_count,
   output logic [2:0] o_state
);

   localparam logic [3:0] GREEN_LOAD  = 4'(GREEN_MIN - 1);
   localparam logic [3:0] YELLOW_LOAD = 4'(YELLOW_T - 1);
   localparam logic [3:0] ALLRED_LOAD = 4'(ALLRED_T - 1);
   localparam logic [3:0] WALK_LOAD   = 4'(WALK_T - 1);

   state_t     state_reg;
   state_t     state_next;
   dir_t       last_dir_reg;
   logic       ped_pend_reg;
   logic       timer_load;
   logic [3:0] timer_value;
   logic [3:0] count;
   logic       count_zero;

   phase_timer u_phase_timer (
      .clk        (in_clk),
      .rst_n      (in_rst_n),
      .load       (timer_load),
      .load_value (timer_value),
      .count      (count),
      .zero       (count_zero)
   );

   // Next-state decision. Every transition enters a different state, so a
   // state change is exactly the moment the phase timer must reload.
   always_comb begin
      state_next  = state_reg;
      timer_load  = 1'b0;
      timer_value = 4'd0;

      unique case (state_reg)
         ST_IDLE: begin
            if (in_en) begin
               state_next = (last_dir_reg == DIR_EW) ? ST_NS_GREEN : ST_EW_GREEN;
            end
         end
         ST_NS_GREEN: begin
            if (count_zero && (in_req_ew || ped_pend_reg || !in_en)) begin
               state_next = ST_NS_YELLOW;
            end
         end
         ST_EW_GREEN: begin
            if (count_zero && (in_req_ns || ped_pend_reg || !in_en)) begin
               state_next = ST_EW_YELLOW;
            end
         end
         ST_NS_YELLOW, ST_EW_YELLOW, ST_PED_WALK: begin
            if (count_zero) begin
               state_next = ST_ALL_RED;
            end
         end
         ST_ALL_RED: begin
            if (count_zero) begin
               if (!in_en) begin
                  state_next = ST_IDLE;
               end else if (ped_pend_reg) begin
                  state_next = ST_PED_WALK;
               end else begin
                  state_next = (last_dir_reg == DIR_EW) ? ST_NS_GREEN : ST_EW_GREEN;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (state_next != state_reg) begin
         timer_load = 1'b1;
         unique case (state_next)
            ST_NS_GREEN, ST_EW_GREEN:   timer_value = GREEN_LOAD;
            ST_NS_YELLOW, ST_EW_YELLOW: timer_value = YELLOW_LOAD;
            ST_ALL_RED:                 timer_value = ALLRED_LOAD;
            ST_PED_WALK:                timer_value = WALK_LOAD;
            default:                    timer_value = 4'd0;  // IDLE shows 0
         endcase
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_reg    <= ST_IDLE;
         last_dir_reg <= RESET_LAST_DIR;
         ped_pend_reg <= 1'b0;
         o_ns_green   <= 1'b0;
         o_ns_yellow  <= 1'b0;
         o_ns_red     <= 1'b1;
         o_ew_green   <= 1'b0;
         o_ew_yellow  <= 1'b0;
         o_ew_red     <= 1'b1;
         o_walk       <= 1'b0;
      end else begin
         state_reg <= state_next;

         // The direction just served is recorded when its yellow ends.
         if (state_reg == ST_NS_YELLOW && state_next == ST_ALL_RED) begin
            last_dir_reg <= DIR_NS;
         end else if (state_reg == ST_EW_YELLOW && state_next == ST_ALL_RED) begin
            last_dir_reg <= DIR_EW;
         end

         // Presses during the walk are dropped; the request is retired as
         // the walk ends.
         if (state_reg == ST_PED_WALK) begin
            if (state_next != ST_PED_WALK) begin
               ped_pend_reg <= 1'b0;
            end
         end else if (in_ped_req) begin
            ped_pend_reg <= 1'b1;
         end

         o_ns_green  <= (state_next == ST_NS_GREEN);
         o_ns_yellow <= (state_next == ST_NS_YELLOW);
         o_ns_red    <= !((state_next == ST_NS_GREEN) || (state_next == ST_NS_YELLOW));
         o_ew_green  <= (state_next == ST_EW_GREEN);
         o_ew_yellow <= (state_next == ST_EW_YELLOW);
         o_ew_red    <= !((state_next == ST_EW_GREEN) || (state_next == ST_EW_YELLOW));
         o_walk      <= (state_next == ST_PED_WALK);
      end
   end

   assign o_count = count;
   assign o_state = state_reg;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
module tb_traffic_intersection_ctrl;
   import traffic_pkg::*;

   localparam int GREEN_MIN = 5;
   localparam int YELLOW_T  = 2;
   localparam int ALLRED_T  = 1;
   localparam int WALK_T    = 4;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       req_ns;
   logic       req_ew;
   logic       ped_req;
   logic       ns_green, ns_yellow, ns_red;
   logic       ew_green, ew_yellow, ew_red;
   logic       walk;
   logic [3:0] count;
   logic [2:0] state;

   int n_compared   = 0;
   int n_mismatched = 0;

   traffic_intersection_ctrl #(
      .GREEN_MIN (GREEN_MIN),
      .YELLOW_T  (YELLOW_T),
      .ALLRED_T  (ALLRED_T),
      .WALK_T    (WALK_T)
   ) dut (
      .in_clk      (clk),
      .in_rst_n    (rst_n),
      .in_en       (en),
      .in_req_ns   (req_ns),
      .in_req_ew   (req_ew),
      .in_ped_req  (ped_req),
      .o_ns_green  (ns_green),
      .o_ns_yellow (ns_yellow),
      .o_ns_red    (ns_red),
      .o_ew_green  (ew_green),
      .o_ew_yellow (ew_yellow),
      .o_ew_red    (ew_red),
      .o_walk      (walk),
      .o_count     (count),
      .o_state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model (phase name + cycles remaining) ----
   typedef enum int {M_IDLE, M_NSG, M_NSY, M_AR, M_WALK, M_EWG, M_EWY} mphase_t;

   mphase_t m_phase;
   int      m_rem;
   bit      m_pend;
   bit      m_last_ew;
   int      m_walks;

   function automatic int phase_len(mphase_t p);
      case (p)
         M_NSG, M_EWG: return GREEN_MIN;
         M_NSY, M_EWY: return YELLOW_T;
         M_AR:         return ALLRED_T;
         M_WALK:       return WALK_T;
         default:      return 1;
      endcase
   endfunction

   function automatic int phase_code(mphase_t p);
      case (p)
         M_NSG:   return int'(ENC_NS_GREEN);
         M_NSY:   return int'(ENC_NS_YELLOW);
         M_AR:    return int'(ENC_ALL_RED);
         M_WALK:  return int'(ENC_PED_WALK);
         M_EWG:   return int'(ENC_EW_GREEN);
         M_EWY:   return int'(ENC_EW_YELLOW);
         default: return int'(ENC_IDLE);
      endcase
   endfunction

   // Lamp vector {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
   function automatic int phase_lamps(mphase_t p);
      bit ng, ny, eg, ey, w;
      ng = (p == M_NSG);
      ny = (p == M_NSY);
      eg = (p == M_EWG);
      ey = (p == M_EWY);
      w  = (p == M_WALK);
      return int'({ng, ny, !(ng || ny), eg, ey, !(eg || ey), w});
   endfunction

   task automatic model_reset();
      m_phase   = M_IDLE;
      m_rem     = 0;
      m_pend    = 1'b0;
      m_last_ew = 1'b1;
   endtask

   task automatic model_edge(bit e, bit rns, bit rew, bit ped);
      mphase_t nxt;
      bit      done;
      nxt  = m_phase;
      done = (m_rem == 0);
      case (m_phase)
         M_IDLE: if (e) nxt = m_last_ew ? M_NSG : M_EWG;
         M_NSG:  if (done && (rew || m_pend || !e)) nxt = M_NSY;
         M_EWG:  if (done && (rns || m_pend || !e)) nxt = M_EWY;
         M_NSY:  if (done) begin nxt = M_AR; m_last_ew = 1'b0; end
         M_EWY:  if (done) begin nxt = M_AR; m_last_ew = 1'b1; end
         M_WALK: if (done) nxt = M_AR;
         M_AR: begin
            if (done) begin
               if (!e)          nxt = M_IDLE;
               else if (m_pend) nxt = M_WALK;
               else             nxt = m_last_ew ? M_NSG : M_EWG;
            end
         end
         default: nxt = M_IDLE;
      endcase
      if (m_phase == M_WALK) begin
         if (nxt != M_WALK) m_pend = 1'b0;
      end else if (ped) begin
         m_pend = 1'b1;
      end
      if (nxt != m_phase) begin
         m_rem = phase_len(nxt) - 1;
         if (nxt == M_WALK) m_walks++;
      end else if (m_rem > 0) begin
         m_rem--;
      end
      m_phase = nxt;
   endtask

   // ---------------- checking ----------------
   task automatic check(string tag, int observed, int expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   function automatic int lamps_obs();
      return int'({ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk});
   endfunction

   task automatic compare_all();
      check("state", int'(state), phase_code(m_phase));
      check("count", int'(count), m_rem);
      check("lamps", lamps_obs(), phase_lamps(m_phase));
      check("walk_safe", int'(walk && (ns_green || ns_yellow || ew_green || ew_yellow)), 0);
   endtask

   // Called at a negedge: apply inputs, let an edge happen, compare.
   task automatic cycle(bit e, bit rns, bit rew, bit ped);
      en      = e;
      req_ns  = rns;
      req_ew  = rew;
      ped_req = ped;
      @(posedge clk);
      model_edge(e, rns, rew, ped);
      @(negedge clk);
      compare_all();
      $display("cyc en=%0b ns=%0b ew=%0b ped=%0b -> state=%0d count=%0d lamps=%07b",
               e, rns, rew, ped, state, count, lamps_obs());
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_state"}, int'(state), int'(ENC_IDLE));
      check({tag, "_count"}, int'(count), 0);
      check({tag, "_lamps"}, lamps_obs(), int'(7'b0010010));
   endtask

   initial begin
      int steps;
      int walks_before;

      rst_n   = 1'b0;
      en      = 1'b0;
      req_ns  = 1'b0;
      req_ew  = 1'b0;
      ped_req = 1'b0;
      model_reset();
      m_walks = 0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // First enabled edge goes to NS green with count GREEN_MIN-1.
      cycle(1, 0, 0, 0);
      check("first_green_state", int'(state), int'(ENC_NS_GREEN));
      check("first_green_count", int'(count), 4);

      // No requests: green holds at count 0.
      repeat (50) cycle(1, 0, 0, 0);
      check("hold_green_state", int'(state), int'(ENC_NS_GREEN));
      check("hold_green_count", int'(count), 0);
      cycle(1, 0, 1, 0);
      check("yield_to_ew", int'(state), int'(ENC_NS_YELLOW));

      // EW request throughout: yellow, all-red, then EW green.
      repeat (12) cycle(1, 0, 1, 0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(15) != 0), ($urandom_range(3) == 0),
               ($urandom_range(3) == 0), ($urandom_range(11) == 0));
      end

      // Drive to EW yellow, then pulse reset mid-phase.
      steps = 0;
      while (m_phase != M_EWY && steps < 200) begin
         cycle(1, 1, 1, 0);
         steps++;
      end
      check("reach_ew_yellow", int'(m_phase == M_EWY), 1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      model_reset();
      @(negedge clk);
      check_reset_outputs("held_reset");
      rst_n = 1'b1;
      cycle(1, 0, 0, 0);
      check("post_reset_green", int'(state), int'(ENC_NS_GREEN));

      // Ped press, then a second press during the walk: exactly one walk.
      walks_before = m_walks;
      cycle(1, 0, 0, 1);
      steps = 0;
      while (m_phase != M_WALK && steps < 100) begin
         cycle(1, 0, 0, 0);
         steps++;
      end
      check("reach_walk", int'(walk), 1);
      cycle(1, 0, 0, 1);
      repeat (40) cycle(1, 0, 0, 0);
      check("single_walk", m_walks - walks_before, 1);
      check("walk_off_after", int'(walk), 0);

      // Orderly stop to IDLE, then restart.
      steps = 0;
      while (m_phase != M_IDLE && steps < 100) begin
         cycle(0, 1, 1, 0);
         steps++;
      end
      check_reset_outputs("idle_stop");
      cycle(1, 0, 0, 0);
      repeat (20) cycle(1, $urandom_range(1), $urandom_range(1), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
